// File: rtl/run_sequencer_if.sv
// Handshake and PC-control bundle between run_sequencer (slave) and the bench/core side (master).
interface run_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             halt_instr;
    logic             step;
    logic             pc_init;
    logic             pc_halt;
    logic             pc_req;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, halt_instr, step,
        input  pc_init, pc_halt, pc_req, busy, done, timeout, cycle_count
    );

    modport slave (
        input  start, halt_instr, step,
        output pc_init, pc_halt, pc_req, busy, done, timeout, cycle_count
    );
endinterface

// File: rtl/run_sequencer.sv
// Run controller: IDLE -> CLEAR -> RUN -> DONE with start/done 4-phase handshake and a RUN watchdog.
// Optional single-step mode under macro RUN_STEP_EN.
module run_sequencer #(
    parameter int CLEAR_CYCLES = 2,
    parameter int MAX_CYCLES   = 4096,
    parameter int CNT_W        = 16
) (
    input  logic            i_clk,
    input  logic            i_init,
    run_sequencer_if.slave  bus
);
    localparam int CLR_W = (CLEAR_CYCLES < 2) ? 1 : $clog2(CLEAR_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [CLR_W-1:0] r_clr_cnt;
    logic [CNT_W-1:0] r_cycle_count;
    logic             r_timeout;
    logic             r_busy;
    logic             r_done;
    logic             r_pc_halt;
    logic             r_in_clear;
    logic             r_pc_req;
    logic             w_adv;
    logic             w_at_limit;

`ifdef RUN_STEP_EN
    localparam logic RUN_HALT = 1'b1;
    logic r_step_d;
    // Only stepped cycles count, sample halt, and feed the watchdog.
    assign w_adv = r_pc_req;
`else
    localparam logic RUN_HALT = 1'b0;
    logic w_unused_step;
    assign w_unused_step = bus.step;
    assign w_adv = 1'b1;
`endif

    assign w_at_limit = (r_cycle_count == CNT_W'(MAX_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_init) begin
            r_state       <= S_IDLE;
            r_clr_cnt     <= '0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pc_halt     <= 1'b1;
            r_in_clear    <= 1'b0;
            r_pc_req      <= 1'b0;
`ifdef RUN_STEP_EN
            r_step_d      <= 1'b0;
`endif
        end else begin
            r_pc_req <= 1'b0;
`ifdef RUN_STEP_EN
            r_step_d <= bus.step;
`endif
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state       <= S_CLEAR;
                        r_cycle_count <= '0;
                        r_timeout     <= 1'b0;
                        r_clr_cnt     <= '0;
                        r_busy        <= 1'b1;
                        r_in_clear    <= 1'b1;
                        r_pc_halt     <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + CLR_W'(1);
                    if (r_clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) begin
                        r_state    <= S_RUN;
                        r_in_clear <= 1'b0;
                        r_pc_halt  <= RUN_HALT;
                    end
                end
                S_RUN: begin
                    if (w_adv) begin
                        // Halt beats the watchdog; the HALT cycle is counted, the timeout cycle is not.
                        if (bus.halt_instr) begin
                            r_cycle_count <= r_cycle_count + CNT_W'(1);
                            r_state       <= S_DONE;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                            r_pc_halt     <= 1'b1;
                        end else if (w_at_limit) begin
                            r_timeout     <= 1'b1;
                            r_state       <= S_DONE;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                            r_pc_halt     <= 1'b1;
                        end else begin
                            r_cycle_count <= r_cycle_count + CNT_W'(1);
                        end
                    end
`ifdef RUN_STEP_EN
                    else begin
                        r_pc_req <= bus.step & ~r_step_d;
                    end
`endif
                end
                S_DONE: begin
                    if (!bus.start) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_pc_halt  <= 1'b1;
                    r_in_clear <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_init     = i_init | r_in_clear;
    assign bus.pc_halt     = r_pc_halt;
    assign bus.pc_req      = r_pc_req;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.timeout     = r_timeout;
    assign bus.cycle_count = r_cycle_count;
endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer (CLEAR_CYCLES=2, MAX_CYCLES=16); step tests when RUN_STEP_EN is defined.
module tb_run_sequencer;
    logic clk  = 1'b0;
    logic init = 1'b1;
    int   checks = 0;
    int   errors = 0;

    run_sequencer_if #(.CNT_W(16)) bus();

    run_sequencer #(
        .CLEAR_CYCLES(2),
        .MAX_CYCLES  (16),
        .CNT_W       (16)
    ) dut (
        .i_clk (clk),
        .i_init(init),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.halt_instr = 1'b0; bus.step = 1'b0;
        init = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.pc_init, bus.pc_halt, bus.pc_req, bus.busy, bus.done} !== 5'b11000) begin
                errors++;
                $display("FAIL reset_outs cyc%0d: got %b expected 11000", i,
                         {bus.pc_init, bus.pc_halt, bus.pc_req, bus.busy, bus.done});
            end
        end
        checks++;
        if (bus.cycle_count !== 16'd0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt: got cnt=%0d to=%b expected 0/0", bus.cycle_count, bus.timeout);
        end
        init = 1'b0;
        tick();
        checks++;
        if ({bus.pc_init, bus.pc_halt, bus.busy, bus.done} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_release: got %b expected 0100",
                     {bus.pc_init, bus.pc_halt, bus.busy, bus.done});
        end
    endtask

`ifndef RUN_STEP_EN
    task automatic test_halt_run();
        bus.start = 1'b1;
        tick();
        checks++;
        if (bus.pc_init !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL clear1: got init=%b busy=%b expected 1/1", bus.pc_init, bus.busy);
        end
        tick();
        checks++;
        if (bus.pc_init !== 1'b1) begin
            errors++;
            $display("FAIL clear2: got init=%b expected 1", bus.pc_init);
        end
        tick();
        checks++;
        if ({bus.pc_init, bus.busy, bus.pc_halt} !== 3'b010 || bus.cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL run_entry: got ibh=%b cnt=%0d expected 010/0",
                     {bus.pc_init, bus.busy, bus.pc_halt}, bus.cycle_count);
        end
        for (int i = 0; i < 9; i++) begin
            bus.step = ~bus.step;
            tick();
        end
        checks++;
        if (bus.cycle_count !== 16'd9 || bus.pc_req !== 1'b0) begin
            errors++;
            $display("FAIL run_count9: got cnt=%0d req=%b expected 9/0", bus.cycle_count, bus.pc_req);
        end
        bus.step = 1'b0;
        bus.halt_instr = 1'b1;
        tick();
        bus.halt_instr = 1'b0;
        checks++;
        if ({bus.done, bus.timeout, bus.busy, bus.pc_halt} !== 4'b1001 || bus.cycle_count !== 16'd10) begin
            errors++;
            $display("FAIL halt_done: got dtbh=%b cnt=%0d expected 1001/10",
                     {bus.done, bus.timeout, bus.busy, bus.pc_halt}, bus.cycle_count);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: got %b expected 1", bus.done);
        end
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cycle_count !== 16'd10) begin
            errors++;
            $display("FAIL done_drop: got d=%b b=%b cnt=%0d expected 0/0/10", bus.done, bus.busy, bus.cycle_count);
        end
    endtask

    task automatic test_timeout();
        bus.start = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.cycle_count !== 16'd15) begin
            errors++;
            $display("FAIL wd_pre: got b=%b d=%b cnt=%0d expected 1/0/15", bus.busy, bus.done, bus.cycle_count);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.timeout !== 1'b1 || bus.cycle_count !== 16'd15) begin
            errors++;
            $display("FAIL wd_fire: got d=%b t=%b cnt=%0d expected 1/1/15", bus.done, bus.timeout, bus.cycle_count);
        end
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.timeout !== 1'b1 || bus.cycle_count !== 16'd15) begin
            errors++;
            $display("FAIL wd_idle_hold: got d=%b t=%b cnt=%0d expected 0/1/15", bus.done, bus.timeout, bus.cycle_count);
        end
    endtask

    task automatic test_halt_at_limit();
        bus.start = 1'b1;
        tick();
        checks++;
        if (bus.cycle_count !== 16'd0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL start_clears: got cnt=%0d t=%b expected 0/0", bus.cycle_count, bus.timeout);
        end
        tick(); tick();
        for (int i = 0; i < 15; i++) tick();
        bus.halt_instr = 1'b1;
        tick();
        bus.halt_instr = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.timeout !== 1'b0 || bus.cycle_count !== 16'd16) begin
            errors++;
            $display("FAIL halt_at_limit: got d=%b t=%b cnt=%0d expected 1/0/16", bus.done, bus.timeout, bus.cycle_count);
        end
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bus.start = 1'b1;
        tick(); tick(); tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.cycle_count !== 16'd3) begin
            errors++;
            $display("FAIL start_drop_run: got b=%b cnt=%0d expected 1/3", bus.busy, bus.cycle_count);
        end
        bus.halt_instr = 1'b1;
        tick();
        bus.halt_instr = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.cycle_count !== 16'd4) begin
            errors++;
            $display("FAIL b2b_done1: got d=%b cnt=%0d expected 1/4", bus.done, bus.cycle_count);
        end
        tick();
        bus.start = 1'b1;
        tick();
        checks++;
        if ({bus.done, bus.busy, bus.pc_init} !== 3'b011 || bus.cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL b2b_restart: got dbi=%b cnt=%0d expected 011/0",
                     {bus.done, bus.busy, bus.pc_init}, bus.cycle_count);
        end
        tick(); tick();
        bus.halt_instr = 1'b1;
        tick();
        bus.halt_instr = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.cycle_count !== 16'd1) begin
            errors++;
            $display("FAIL b2b_done2: got d=%b cnt=%0d expected 1/1", bus.done, bus.cycle_count);
        end
        bus.start = 1'b0;
        tick();
    endtask
`endif

    task automatic test_init_mid_run();
        int d_seen;
        bus.start = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) tick();
`ifndef RUN_STEP_EN
        checks++;
        if (bus.cycle_count !== 16'd4 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort: got cnt=%0d b=%b expected 4/1", bus.cycle_count, bus.busy);
        end
`endif
        init = 1'b1;
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.pc_init !== 1'b1) begin
            errors++;
            $display("FAIL abort_pcinit: got %b expected 1", bus.pc_init);
        end
        tick();
        checks++;
        if ({bus.busy, bus.pc_halt, bus.done, bus.pc_init} !== 4'b0101 || bus.cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL abort_idle: got bhdi=%b cnt=%0d expected 0101/0",
                     {bus.busy, bus.pc_halt, bus.done, bus.pc_init}, bus.cycle_count);
        end
        init = 1'b0;
        d_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            d_seen += int'(bus.done);
        end
        checks++;
        if (d_seen !== 0 || bus.pc_init !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone: got done_cycles=%0d i=%b b=%b expected 0/0/0", d_seen, bus.pc_init, bus.busy);
        end
    endtask

`ifdef RUN_STEP_EN
    task automatic test_step();
        int reqs;
        bus.start = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({bus.busy, bus.pc_halt, bus.pc_req} !== 3'b110) begin
            errors++;
            $display("FAIL step_entry: got bhr=%b expected 110", {bus.busy, bus.pc_halt, bus.pc_req});
        end
        bus.halt_instr = 1'b1;
        tick();
        bus.halt_instr = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL step_halt_ignored: got b=%b d=%b expected 1/0", bus.busy, bus.done);
        end
        reqs = 0;
        for (int i = 0; i < 3; i++) begin
            bus.step = 1'b1; tick(); reqs += int'(bus.pc_req);
            bus.step = 1'b0; tick(); reqs += int'(bus.pc_req);
        end
        checks++;
        if (reqs !== 3 || bus.cycle_count !== 16'd3) begin
            errors++;
            $display("FAIL step_pulses: got reqs=%0d cnt=%0d expected 3/3", reqs, bus.cycle_count);
        end
        reqs = 0;
        bus.step = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); reqs += int'(bus.pc_req); end
        bus.step = 1'b0;
        tick(); reqs += int'(bus.pc_req);
        checks++;
        if (reqs !== 1 || bus.cycle_count !== 16'd4) begin
            errors++;
            $display("FAIL step_held: got reqs=%0d cnt=%0d expected 1/4", reqs, bus.cycle_count);
        end
        bus.step = 1'b1;
        tick();
        bus.halt_instr = 1'b1;
        bus.step = 1'b0;
        tick();
        bus.halt_instr = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.cycle_count !== 16'd5 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL step_halt: got d=%b cnt=%0d t=%b expected 1/5/0", bus.done, bus.cycle_count, bus.timeout);
        end
        bus.start = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
`ifdef RUN_STEP_EN
        test_step();
`else
        test_halt_run();
        test_timeout();
        test_halt_at_limit();
        test_back_to_back();
`endif
        test_init_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
